lifo: RTL and testbench

LIFO -- requirements
Module: lifo

---
 rtl/lifo.sv | 101 ++++++++++
 tb/tb_lifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lifo.sv
// Parameterised register-file LIFO with registered pop data and strobe outputs.
// Build option: define LIFO_OVERWRITE_EN to make a push into a full stack overwrite circularly.
module lifo #(
   parameter int STACK_WIDTH = 18,
   parameter int STACK_SIZE  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [STACK_WIDTH-1:0] data_in,
   output logic [STACK_WIDTH-1:0] data_out,
   output logic                   data_valid,
   output logic [STACK_SIZE:0]    count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int DEPTH = 2**STACK_SIZE;
   localparam logic [STACK_SIZE:0] FULL_CNT = DEPTH[STACK_SIZE:0];

   logic [STACK_WIDTH-1:0] mem [DEPTH];
   logic [STACK_SIZE-1:0]  ptr;
   logic [STACK_SIZE-1:0]  top;
   logic                   wr_en;
   logic [STACK_SIZE-1:0]  wr_addr;
   logic                   act;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign top   = ptr - 1'b1;
   assign act   = !reset && !clear;

   // Push+pop on a non-empty stack replaces the top word in place.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = ptr;
      if (act) begin
         if (push && pop && !empty) begin
            wr_en   = 1'b1;
            wr_addr = top;
         end else if (push && !pop) begin
`ifdef LIFO_OVERWRITE_EN
            wr_en = 1'b1;
`else
            wr_en = !full;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         count      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         if (clear) begin
            ptr   <= '0;
            count <= '0;
         end else if (push && pop) begin
            data_valid <= 1'b1;
            data_out   <= empty ? data_in : mem[top];
         end else if (pop) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               data_out   <= mem[top];
               data_valid <= 1'b1;
               ptr        <= top;
               count      <= count - 1'b1;
            end
         end else if (push) begin
            if (!full) begin
               ptr   <= ptr + 1'b1;
               count <= count + 1'b1;
            end else begin
               overflow <= 1'b1;
`ifdef LIFO_OVERWRITE_EN
               // Oldest word is lost; depth stays saturated.
               ptr <= ptr + 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_lifo.sv
// Directed bench for lifo at STACK_SIZE=2 (depth 4); honours LIFO_OVERWRITE_EN.
module tb_lifo;

   logic        clk = 1'b0;
   logic        reset, clear, push, pop;
   logic [17:0] data_in;
   logic [17:0] data_out;
   logic        data_valid, full, empty, overflow, underflow;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   lifo #(.STACK_WIDTH(18), .STACK_SIZE(2)) dut (
      .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop),
      .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
      .count(count), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic rs, input logic cl, input logic pu, input logic po,
                       input logic [17:0] d);
      reset = rs; clear = cl; push = pu; pop = po; data_in = d;
      @(posedge clk);
      #1;
      reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
   endtask

   task automatic do_push(input logic [17:0] d);
      step(1'b0, 1'b0, 1'b1, 1'b0, d);
   endtask

   task automatic do_pop();
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
   endtask

   logic [17:0] exp_ovf [4];

   initial begin
`ifdef LIFO_OVERWRITE_EN
      exp_ovf[0] = 18'h5; exp_ovf[1] = 18'h4; exp_ovf[2] = 18'h3; exp_ovf[3] = 18'h2;
`else
      exp_ovf[0] = 18'h4; exp_ovf[1] = 18'h3; exp_ovf[2] = 18'h2; exp_ovf[3] = 18'h1;
`endif
      reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);

      // Underflow after reset
      do_pop();
      chk("udf_strobe", underflow, 1);
      chk("udf_dv", data_valid, 0);
      chk("udf_dout", data_out, 0);
      chk("udf_count", count, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("udf_clear", underflow, 0);

      // Basic LIFO order
      do_push(18'h11);
      chk("push_dv", data_valid, 0);
      do_push(18'h22);
      do_push(18'h33);
      chk("p3_count", count, 3);
      do_pop();
      chk("pop1_dout", data_out, 18'h33); chk("pop1_dv", data_valid, 1); chk("pop1_cnt", count, 2);
      do_pop();
      chk("pop2_dout", data_out, 18'h22); chk("pop2_dv", data_valid, 1);
      do_pop();
      chk("pop3_dout", data_out, 18'h11); chk("pop3_dv", data_valid, 1);
      chk("pop3_empty", empty, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("idle_dv", data_valid, 0);
      chk("idle_dout", data_out, 18'h11);

      // Simultaneous push+pop
      do_push(18'hA);
      do_push(18'hB);
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'hC);
      chk("pp_dout", data_out, 18'hB); chk("pp_cnt", count, 2); chk("pp_dv", data_valid, 1);
      do_pop();
      chk("pp_pop_c", data_out, 18'hC); chk("pp_pop_cnt", count, 1);
      do_pop();
      chk("pp_pop_a", data_out, 18'hA); chk("pp_empty", empty, 1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h5);
      chk("ppe_dout", data_out, 18'h5); chk("ppe_cnt", count, 0);
      chk("ppe_dv", data_valid, 1); chk("ppe_udf", underflow, 0);

      // Fill, push while full
      for (int i = 1; i <= 4; i++) do_push(18'(i));
      chk("fill_full", full, 1);
      chk("fill_cnt", count, 4);
      do_push(18'h5);
      chk("ovf_strobe", overflow, 1);
      chk("ovf_cnt", count, 4);
      chk("ovf_full", full, 1);
      for (int i = 0; i < 4; i++) begin
         do_pop();
         chk($sformatf("ovf_pop%0d", i), data_out, exp_ovf[i]);
         if (i == 0) chk("ovf_gone", overflow, 0);
      end
      chk("ovf_empty", empty, 1);

      // Push+pop while full replaces top, no overflow
      for (int i = 1; i <= 4; i++) do_push(18'(i));
      step(1'b0, 1'b0, 1'b1, 1'b1, 18'h9);
      chk("ppf_dout", data_out, 18'h4); chk("ppf_ovf", overflow, 0); chk("ppf_cnt", count, 4);
      do_pop(); chk("ppf_pop0", data_out, 18'h9);
      do_pop(); chk("ppf_pop1", data_out, 18'h3);
      do_pop(); chk("ppf_pop2", data_out, 18'h2);
      do_pop(); chk("ppf_pop3", data_out, 18'h1);

      // Clear overrides push
      do_push(18'h21); do_push(18'h22); do_push(18'h23);
      step(1'b0, 1'b1, 1'b1, 1'b0, 18'h3F);
      chk("clr_cnt", count, 0); chk("clr_empty", empty, 1);
      chk("clr_dout", data_out, 18'h1); chk("clr_dv", data_valid, 0);
      do_push(18'h7);
      chk("clr_push_cnt", count, 1);
      do_pop();
      chk("clr_pop", data_out, 18'h7);

      // Reset mid-sequence with pop
      do_push(18'h31); do_push(18'h32);
      step(1'b1, 1'b0, 1'b0, 1'b1, '0);
      chk("mrst_dout", data_out, 0); chk("mrst_cnt", count, 0); chk("mrst_dv", data_valid, 0);
      do_pop();
      chk("mrst_udf", underflow, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
